// File: rtl/tff_bist_pkg.sv
// Shared types and LFSR helpers for the T flip-flop self-test engine.
package tff_bist_pkg;

  localparam int               LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    RST_DUT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Galois right-shift step: feed the outgoing LSB back through the tap mask.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/tff_bist_lfsr.sv
// Toggle-pattern LFSR: reloads SEED on request, steps only when advanced.
module tff_bist_lfsr
  import tff_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_adv,
  output logic o_lsb
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_adv) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_lsb = r_state[0];

endmodule

// File: rtl/tff_bist.sv
// Stimulus/check engine for a T flip-flop: drives t/rst, tracks a golden q,
// and counts (saturating) cycles where the DUT q disagrees.
module tff_bist
  import tff_bist_pkg::*;
#(
  parameter int               NUM_VECTORS = 64,
  parameter int               RST_CYCLES  = 2,
  parameter int               INJ_PERIOD  = 16,
  parameter logic [LFSR_W-1:0] SEED        = 8'hA5,
  parameter int               ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             tff_t,
  output logic             tff_rst,
  input  logic             tff_q
);

  localparam int CNT_MAX0 = (NUM_VECTORS > RST_CYCLES) ? NUM_VECTORS : RST_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int INJ_W    = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [INJ_W-1:0] r_inj;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic             r_tff_t;
  logic             r_tff_rst;
  logic             r_exp_q;
  logic             r_chk_en;

  logic             w_inj;
  logic             w_load;
  logic             w_adv;
  logic             w_lfsr_lsb;
  logic [ERR_W-1:0] w_err_next;

  assign w_inj  = (INJ_PERIOD != 0) && (r_inj == INJ_W'(INJ_PERIOD - 1));
  assign w_load = (r_state == IDLE) && start;
  assign w_adv  = (r_state == RUN) && !w_inj;

  // The final drain compare lands on the DONE edge, so pass must see it too.
  assign w_err_next = (r_chk_en && (tff_q != r_exp_q) && (r_err != ERR_MAX))
                      ? r_err + ERR_W'(1) : r_err;

  tff_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_adv  (w_adv),
    .o_lsb  (w_lfsr_lsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_inj     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_tff_t   <= 1'b0;
      r_tff_rst <= 1'b1;
      r_exp_q   <= 1'b0;
      r_chk_en  <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_exp_q  <= r_tff_rst ? 1'b0 : (r_exp_q ^ r_tff_t);
      r_chk_en <= !r_tff_rst && ((r_state == RUN) || (r_state == DRAIN));
      r_err    <= w_err_next;
      case (r_state)
        IDLE: begin
          r_tff_t   <= 1'b0;
          r_tff_rst <= 1'b1;
          if (start) begin
            r_state <= RST_DUT;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_cnt   <= '0;
          end
        end
        RST_DUT: begin
          r_tff_t   <= 1'b0;
          r_tff_rst <= 1'b1;
          if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_inj   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (w_inj) begin
            r_tff_t   <= 1'b0;
            r_tff_rst <= 1'b1;
            r_inj     <= '0;
          end else begin
            r_tff_t   <= w_lfsr_lsb;
            r_tff_rst <= 1'b0;
            r_inj     <= r_inj + INJ_W'(1);
          end
          if (r_cnt == CNT_W'(NUM_VECTORS - 1)) begin
            r_state <= DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          r_tff_t   <= 1'b0;
          r_tff_rst <= 1'b0;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_pass    <= (w_err_next == '0);
          r_tff_t   <= 1'b0;
          r_tff_rst <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign tff_t     = r_tff_t;
  assign tff_rst   = r_tff_rst;

endmodule

// File: tb/tb_tff_bist.sv
// Randomised scoreboard bench for tff_bist against behavioural TFF models.
module tb_tff_bist;

  localparam int R  = 2;
  localparam int NA = 64;
  localparam int IA = 16;
  localparam int NB = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start_a = 1'b0, busy_a, done_a, pass_a, tff_t_a, tff_rst_a, tff_q_a;
  logic [7:0] err_a;
  logic       start_b = 1'b0, busy_b, done_b, pass_b, tff_t_b, tff_rst_b, tff_q_b;
  logic [7:0] err_b;

  // fault modes: 0 ideal, 1 stuck-at-0, 2 inverted q, 3 ignores reset
  int   mode_a = 0, mode_b = 0;
  logic tq_a = 1'b0, nq_a = 1'b0, tq_b = 1'b0;

  int checks = 0, errors = 0, cyc = 0;

  int         exp_err_a[$];
  bit         exp_pass_a[$];
  logic [1:0] exp_seq_a[$];
  int         exp_err_b[$];
  bit         exp_pass_b[$];
  int         done_t_a[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tff_bist u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .tff_t(tff_t_a), .tff_rst(tff_rst_a),
    .tff_q(tff_q_a)
  );

  tff_bist #(.NUM_VECTORS(NB), .INJ_PERIOD(0), .ERR_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .tff_t(tff_t_b), .tff_rst(tff_rst_b),
    .tff_q(tff_q_b)
  );

  always @(posedge clk) begin
    tq_a <= tff_rst_a ? 1'b0 : (tq_a ^ tff_t_a);
    nq_a <= nq_a ^ tff_t_a;
    tq_b <= tff_rst_b ? 1'b0 : (tq_b ^ tff_t_b);
  end

  assign tff_q_a = (mode_a == 1) ? 1'b0 : (mode_a == 2) ? ~tq_a : (mode_a == 3) ? nq_a : tq_a;
  assign tff_q_b = (mode_b == 1) ? 1'b0 : (mode_b == 2) ? ~tq_b : tq_b;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit pick(input int mode, input bit tq, input bit nq);
    case (mode)
      1:       return 1'b0;
      2:       return ~tq;
      3:       return nq;
      default: return tq;
    endcase
  endfunction

  // Expected mismatch total: one compare per non-injected vector plus one drain compare.
  function automatic int model_errs(input int n, input int inj, input int mode, input bit q0, input int errw);
    bit [7:0] l = 8'hA5;
    bit gold = 1'b0, tq = 1'b0, nq = q0, t;
    int e = 0, lim;
    for (int v = 0; v < n; v++) begin
      if (inj != 0 && ((v + 1) % inj) == 0) begin
        gold = 1'b0;
        tq   = 1'b0;
      end else begin
        t    = l[0];
        gold = gold ^ t;
        tq   = tq ^ t;
        nq   = nq ^ t;
        if (pick(mode, tq, nq) != gold) e++;
        l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
      end
    end
    if (pick(mode, tq, nq) != gold) e++;
    lim = (1 << errw) - 1;
    return (e > lim) ? lim : e;
  endfunction

  // Expected {tff_rst, tff_t} for every busy cycle of one run.
  task automatic push_seq_a();
    bit [7:0] l = 8'hA5;
    for (int k = 0; k <= R; k++) exp_seq_a.push_back(2'b10);
    for (int v = 0; v < NA; v++) begin
      if (((v + 1) % IA) == 0) exp_seq_a.push_back(2'b10);
      else begin
        exp_seq_a.push_back({1'b0, l[0]});
        l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
      end
    end
    exp_seq_a.push_back(2'b00);
    exp_seq_a.push_back(2'b00);
  endtask

  task automatic expect_a(input int mode);
    int e;
    e = model_errs(NA, IA, mode, nq_a, 8);
    exp_err_a.push_back(e);
    exp_pass_a.push_back(e == 0);
    push_seq_a();
  endtask

  // Monitor for instance A: pops the scoreboard on every done pulse.
  initial begin
    logic [1:0] cap[$];
    logic [1:0] ev;
    int mism;
    forever begin
      @(negedge clk);
      if (rst) cap.delete();
      else begin
        if (busy_a) cap.push_back({tff_rst_a, tff_t_a});
        if (done_a) begin
          done_t_a.push_back(cyc);
          if (exp_err_a.size() == 0) begin
            check("unexpected_done_a", 1, 0);
          end else begin
            check("err_a", err_a, exp_err_a.pop_front());
            check("pass_a", pass_a, exp_pass_a.pop_front());
            check("busy_len_a", cap.size(), R + NA + 3);
            mism = 0;
            for (int k = 0; k < R + NA + 3; k++) begin
              ev = exp_seq_a.pop_front();
              if (k >= cap.size() || cap[k] != ev) mism++;
            end
            check("tseq_a", mism, 0);
          end
          cap.delete();
        end
      end
    end
  end

  // Monitor for instance B.
  initial begin
    int blen = 0;
    forever begin
      @(negedge clk);
      if (rst) blen = 0;
      else begin
        if (busy_b) blen++;
        if (done_b) begin
          if (exp_err_b.size() == 0) check("unexpected_done_b", 1, 0);
          else begin
            check("err_b", err_b, exp_err_b.pop_front());
            check("pass_b", pass_b, exp_pass_b.pop_front());
            check("busy_len_b", blen, NB + R + 3);
          end
          blen = 0;
        end
      end
    end
  end

  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input bit poke);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
      else if (poke && busy_a && $urandom_range(0, 15) == 0) begin
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
      end
    end
    check("timeout_a", seen, 1);
  endtask

  task automatic run_a(input int mode);
    mode_a = mode;
    expect_a(mode);
    pulse_a();
    wait_done_a(400, 1'b1);
    repeat ($urandom_range(0, 5)) @(negedge clk);
  endtask

  task automatic run_b(input int mode);
    int  e;
    bit  seen = 1'b0;
    mode_b = mode;
    e = model_errs(NB, 0, mode, 1'b0, 8);
    exp_err_b.push_back(e);
    exp_pass_b.push_back(e == 0);
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (done_b) seen = 1'b1;
    end
    check("timeout_b", seen, 1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_pass"}, pass_a, 0);
    check({tag, "_err"}, err_a, 0);
    check({tag, "_t"}, tff_t_a, 0);
    check({tag, "_rst"}, tff_rst_a, 1);
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    rst = 1'b0;

    // every fault mode once, then a few random ones
    run_a(0);
    run_a(1);
    run_a(2);
    run_a(3);
    for (int i = 0; i < 3; i++) run_a($urandom_range(0, 3));

    // abort at vector 20: immediate return to reset values, no done
    mode_a = 0;
    pulse_a();
    repeat (R + 20) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_a("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", exp_err_a.size(), 0);
    run_a(0);

    // start held high: one run, then a second accepted right after returning to IDLE
    mode_a = 0;
    expect_a(0);
    expect_a(0);
    t0 = done_t_a.size();
    @(negedge clk);
    start_a = 1'b1;
    repeat (100) @(posedge clk);
    #1 start_a = 1'b0;
    wait_done_a(200, 1'b0);
    repeat (10) @(negedge clk);
    check("held_runs", done_t_a.size() - t0, 2);
    if (done_t_a.size() - t0 == 2)
      check("held_gap", done_t_a[t0 + 1] - done_t_a[t0], R + NA + 4);

    // long run: ideal, saturating inverted, stuck-at-0
    run_b(0);
    run_b(2);
    run_b(1);

    repeat (5) @(negedge clk);
    check("pending_a", exp_err_a.size(), 0);
    check("pending_b", exp_err_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1, "bench timeout");
  end

endmodule
